clk_source_gen: RTL
===================

// Module: clk_source_gen
// PURPOSE
//   Board-level front end for the clock-select stage. From one board clock it produces
//   three divided square-wave clocks: clkFast, clkMedium and clkSlow.
//   It also produces synchronized, debounced copies of the sw2/sw1 select switches.
//   All five outputs feed the clock-select stage directly.
// PARAMETERS
//   DIV_FAST     25_000_000  half-period of clkFast, in clk cycles (>=1)
//   DIV_MEDIUM   50_000_000  half-period of clkMedium, in clk cycles (>=1)
//   DIV_SLOW     100_000_000 half-period of clkSlow, in clk cycles (>=1)
//   DEBOUNCE     1_000_000   cycles a switch must hold a new level before it is accepted (>=1)
// PORTS
//   clk          in   1  board clock; every register is on its rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   swRaw2       in   1  raw slide switch 2 (asynchronous, bouncy)
//   swRaw1       in   1  raw slide switch 1 (asynchronous, bouncy)
//   clkFast      out  1  divided clock, period 2*DIV_FAST clk cycles, 50% duty
//   clkMedium    out  1  divided clock, period 2*DIV_MEDIUM clk cycles, 50% duty
//   clkSlow      out  1  divided clock, period 2*DIV_SLOW clk cycles, 50% duty
//   sw2          out  1  debounced swRaw2
//   sw1          out  1  debounced swRaw1
// BEHAVIOUR
//   Reset
//   - rst_n=0 immediately clears all counters, sync flops and outputs to 0, no clk needed.
//   - Outputs stay 0 until the first rising clk edge after rst_n returns to 1.
//   Divider (one per output)
//   - Counter width is $clog2(DIV)+1.
//   - Each clk edge: if cnt==DIV-1 then cnt<=0 and the output toggles; otherwise cnt<=cnt+1.
//   - The first toggle, 0->1, happens on the DIV-th clk edge after reset release.
//   - DIV=1 toggles every cycle, giving clk/2.
//   - Wrap-around is exact; no drift, no dropped edges.
//   - The three dividers are independent and are not phase-aligned beyond the common reset.
//   Debounce (one per switch)
//   - 2-FF synchronizer first, then an accept counter.
//   - If synced==stable: counter<=0.
//   - Otherwise counter increments. When counter==DEBOUNCE-1, stable<=synced and counter<=0.
//   - Any bounce back to the stable level before acceptance clears the counter.
//   - Latency from a clean raw edge to the output changing is 2+DEBOUNCE clk cycles.
//   - The two switches are handled independently; a simultaneous change on both is legal.
//   Registering
//   - All outputs come straight from flops; there is no combinational path from input to output.
//   - Illegal parameter values (DIV<1 or DEBOUNCE<1) are rejected by an elaboration-time check.
// CONFIGURATION
//   CLK_SOURCE_TICK_EN
//   - Defined: adds three out ports, 1 bit each: tickFast, tickMedium, tickSlow.
//   - Each tick is a one-clk-cycle pulse, registered, asserted in the cycle its divided
//     clock is high for the first time, i.e. the same edge as the 0->1 toggle.
//   - Ticks reset to 0.
//   - They let downstream logic use clock enables instead of the derived clocks.
//   - Undefined: the tick ports and their logic do not exist. The rest of the block is identical.
// STRUCTURE
//   Package clk_source_pkg
//   - Default divisor and debounce constants (board 50 MHz: 0.5 / 1 / 2 s half-periods;
//     20 ms debounce).
//   - Simulation-scale constants for the bench.
//   Sub-module clk_div_stage
//   - Parameter DIV; ports clk, rst_n, clkOut, plus tick when CLK_SOURCE_TICK_EN is defined.
//   - Instantiated three times.
//   Debounce logic
//   - Stays inline as a generate loop over the two switches.
// TESTING  (bench params: DIV_FAST=2, DIV_MEDIUM=4, DIV_SLOW=8, DEBOUNCE=4)
//   1. Reset
//      - Hold rst_n=0 for 10 cycles: all outputs 0.
//      - Assert rst_n=0 mid-run while clkSlow=1: all outputs 0 at once, with no clk edge.
//   2. Divider periods
//      - Release reset and run 64 cycles.
//      - clkFast: first rise on edge 2, period 4.
//      - clkMedium: first rise on edge 4, period 8.
//      - clkSlow: first rise on edge 8, period 16.
//      - All three at 50% duty, with no missed toggle across wrap.
//   3. Clean switch edge
//      - swRaw1 0->1 held: sw1 rises exactly 6 cycles later. sw2 is unaffected.
//   4. Bounce rejection
//      - swRaw2 pulses high 3 cycles, low 1, high 3: sw2 stays 0.
//      - Then swRaw2 held high: sw2 rises 6 cycles after the last rise.
//   5. Simultaneous switches
//      - swRaw2 and swRaw1 both go 0->1 in the same cycle: sw2 and sw1 rise in the same cycle.
//   6. Ticks (CLK_SOURCE_TICK_EN defined)
//      - tickFast is high for exactly 1 cycle per clkFast period, coincident with clkFast rising.
//      - Over 64 cycles the counts are 16 tickFast, 8 tickMedium, 4 tickSlow.

Source files
------------

// File: rtl/clk_source_pkg.sv
// =============================================================================
// Module : clk_source_pkg
// Brief  : Divisor/debounce constants and sizing helper for clk_source_gen.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package clk_source_pkg;

  // Board build: 50 MHz clock, 0.5 / 1 / 2 s half-periods, 20 ms debounce
  localparam int DEF_DIV_FAST   = 25_000_000;
  localparam int DEF_DIV_MEDIUM = 50_000_000;
  localparam int DEF_DIV_SLOW   = 100_000_000;
  localparam int DEF_DEBOUNCE   = 1_000_000;

  // Simulation-scale values
  localparam int SIM_DIV_FAST   = 2;
  localparam int SIM_DIV_MEDIUM = 4;
  localparam int SIM_DIV_SLOW   = 8;
  localparam int SIM_DEBOUNCE   = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_stage.sv
// =============================================================================
// Module : clk_div_stage
// Brief  : Square-wave divider, half-period DIV clk cycles; optional first-high
//          tick when CLK_SOURCE_TICK_EN is defined.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module clk_div_stage
  import clk_source_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CLK_SOURCE_TICK_EN
  output logic tick,
`endif
  output logic clkOut
);

  localparam int            W    = cnt_width(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("clk_div_stage: DIV must be >= 1");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_out_q, clk_out_d;
`ifdef CLK_SOURCE_TICK_EN
  logic         tick_q, tick_d;
`endif

  always_comb begin
    cnt_d     = cnt_q + W'(1);
    clk_out_d = clk_out_q;
`ifdef CLK_SOURCE_TICK_EN
    tick_d    = 1'b0;
`endif
    if (cnt_q == LAST) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
`ifdef CLK_SOURCE_TICK_EN
      // Pulse on the same edge that takes the divided clock high
      tick_d    = ~clk_out_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
`ifdef CLK_SOURCE_TICK_EN
      tick_q    <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
`ifdef CLK_SOURCE_TICK_EN
      tick_q    <= tick_d;
`endif
    end
  end

  assign clkOut = clk_out_q;
`ifdef CLK_SOURCE_TICK_EN
  assign tick   = tick_q;
`endif

endmodule

`default_nettype wire

// File: rtl/clk_source_gen.sv
// =============================================================================
// Module : clk_source_gen
// Brief  : Three divided clocks plus synchronized, debounced sw2/sw1 for the
//          clock-select stage. Define CLK_SOURCE_TICK_EN for tick outputs.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module clk_source_gen
  import clk_source_pkg::*;
#(
  parameter int DIV_FAST   = DEF_DIV_FAST,
  parameter int DIV_MEDIUM = DEF_DIV_MEDIUM,
  parameter int DIV_SLOW   = DEF_DIV_SLOW,
  parameter int DEBOUNCE   = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic swRaw2,
  input  logic swRaw1,
  output logic clkFast,
  output logic clkMedium,
  output logic clkSlow,
`ifdef CLK_SOURCE_TICK_EN
  output logic tickFast,
  output logic tickMedium,
  output logic tickSlow,
`endif
  output logic sw2,
  output logic sw1
);

  localparam int               DB_W    = cnt_width(DEBOUNCE);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);

  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("clk_source_gen: DEBOUNCE must be >= 1");
  end

  clk_div_stage #(.DIV(DIV_FAST)) u_div_fast (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef CLK_SOURCE_TICK_EN
    .tick   (tickFast),
`endif
    .clkOut (clkFast)
  );

  clk_div_stage #(.DIV(DIV_MEDIUM)) u_div_medium (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef CLK_SOURCE_TICK_EN
    .tick   (tickMedium),
`endif
    .clkOut (clkMedium)
  );

  clk_div_stage #(.DIV(DIV_SLOW)) u_div_slow (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef CLK_SOURCE_TICK_EN
    .tick   (tickSlow),
`endif
    .clkOut (clkSlow)
  );

  logic [1:0] sw_raw;
  logic [1:0] sw_stable;

  assign sw_raw = {swRaw2, swRaw1};

  for (genvar i = 0; i < 2; i++) begin : g_debounce
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d  = sw_raw[i];
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      // Any return to the accepted level restarts the hold window
      if (sync2_q != stable_q) begin
        if (cnt_q == DB_LAST) begin
          stable_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign sw_stable[i] = stable_q;
  end

  assign sw2 = sw_stable[1];
  assign sw1 = sw_stable[0];

endmodule

`default_nettype wire
